// File: rtl/iqdemap_sched.sv
// iqdemap_sched
//   Carrier scheduler and output drain controller for the one-segment BPSK
//   demapper. It follows the carrier index inside each OFDM symbol and drops
//   the scattered pilots. The pilot phase advances by PILOT_STEP every symbol.
//   Only data carriers are forwarded to the demapper. The demapper's packed
//   128-bit words are buffered in a 2-entry FIFO toward the host writer.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   ce              carrier-side clock enable (the FIFO side ignores it)
//   sym_start       first carrier of a symbol (qualified by valid_i)
//   valid_i, ar, ai input carrier valid and signed I/Q
//   dm_valid/ar/ai  carrier toward the demapper, 1 cycle after acceptance
//   dm_word_valid   demapper word strobe
//   dm_word         demapper packed word
//   wr_valid        FIFO not empty
//   wr_data         head word of the FIFO
//   wr_ready        writer accepts the head word
//   sym_cnt         completed symbols (wraps)
//   short_err       sticky: a symbol restarted early
//   ovf_err         sticky: a demapper word was dropped on a full FIFO
module iqdemap_sched #(
  parameter int NCAR         = 108,
  parameter int PILOT_PERIOD = 12,
  parameter int PILOT_STEP   = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ce,
  input  logic          sym_start,
  input  logic          valid_i,
  input  logic [10:0]   ar,
  input  logic [10:0]   ai,
  output logic          dm_valid,
  output logic [10:0]   dm_ar,
  output logic [10:0]   dm_ai,
  input  logic          dm_word_valid,
  input  logic [127:0]  dm_word,
  output logic          wr_valid,
  output logic [127:0]  wr_data,
  input  logic          wr_ready,
  output logic [15:0]   sym_cnt,
  output logic          short_err,
  output logic          ovf_err
);

  localparam int KW = (NCAR > 1) ? $clog2(NCAR) : 1;
  localparam int PW = (PILOT_PERIOD > 1) ? $clog2(PILOT_PERIOD) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [KW-1:0] K_LAST   = KW'(NCAR - 1);
  localparam logic [PW-1:0] MOD_LAST = PW'(PILOT_PERIOD - 1);

  // ---------------------------------------------------------------------
  // Carrier side
  // ---------------------------------------------------------------------
  logic [0:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  // Tracks k mod PILOT_PERIOD alongside k, so no divider is needed.
  logic [PW-1:0] mod_q, mod_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          dm_valid_q, dm_valid_d;
  logic [10:0]   dm_ar_q, dm_ar_d;
  logic [10:0]   dm_ai_q, dm_ai_d;
  logic [15:0]   sym_cnt_q, sym_cnt_d;
  logic          short_err_q, short_err_d;

  logic [PW:0]   ph_sum;
  logic [PW-1:0] ph_adv;
  logic          fwd;

  // Pilot phase for the next symbol: (ph + STEP) mod PERIOD, assuming STEP < PERIOD.
  always_comb begin
    ph_sum = {1'b0, ph_q} + (PW+1)'(PILOT_STEP);
    if (ph_sum >= (PW+1)'(PILOT_PERIOD)) begin
      ph_adv = PW'(ph_sum - (PW+1)'(PILOT_PERIOD));
    end else begin
      ph_adv = ph_sum[PW-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    mod_d       = mod_q;
    ph_d        = ph_q;
    dm_valid_d  = dm_valid_q;
    dm_ar_d     = dm_ar_q;
    dm_ai_d     = dm_ai_q;
    sym_cnt_d   = sym_cnt_q;
    short_err_d = short_err_q;
    fwd         = 1'b0;

    // With ce low the whole carrier side, dm_* included, is frozen.
    if (ce) begin
      dm_valid_d = 1'b0;
      if (valid_i) begin
        case (state_q)
          ST_IDLE: begin
            if (sym_start) begin
              // This carrier is index 0; its pilot test is 0 == ph.
              fwd     = (ph_q != '0);
              state_d = ST_RUN;
              k_d     = KW'(1);
              mod_d   = (PILOT_PERIOD > 1) ? PW'(1) : '0;
            end
          end
          ST_RUN: begin
            if (sym_start && (k_q != '0)) begin
              // Early restart: the symbol is abandoned without being counted.
              // The phase still advances, and this carrier becomes index 0
              // under the new phase.
              short_err_d = 1'b1;
              ph_d        = ph_adv;
              fwd         = (ph_adv != '0);
              k_d         = KW'(1);
              mod_d       = (PILOT_PERIOD > 1) ? PW'(1) : '0;
            end else begin
              fwd = (mod_q != ph_q);
              if (k_q == K_LAST) begin
                sym_cnt_d = sym_cnt_q + 16'd1;
                ph_d      = ph_adv;
                state_d   = ST_IDLE;
                k_d       = '0;
                mod_d     = '0;
              end else begin
                k_d   = k_q + KW'(1);
                mod_d = (mod_q == MOD_LAST) ? '0 : mod_q + PW'(1);
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase

        if (fwd) begin
          dm_valid_d = 1'b1;
          dm_ar_d    = ar;
          dm_ai_d    = ai;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      mod_q       <= '0;
      ph_q        <= '0;
      dm_valid_q  <= 1'b0;
      dm_ar_q     <= '0;
      dm_ai_q     <= '0;
      sym_cnt_q   <= '0;
      short_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mod_q       <= mod_d;
      ph_q        <= ph_d;
      dm_valid_q  <= dm_valid_d;
      dm_ar_q     <= dm_ar_d;
      dm_ai_q     <= dm_ai_d;
      sym_cnt_q   <= sym_cnt_d;
      short_err_q <= short_err_d;
    end
  end

  assign dm_valid  = dm_valid_q;
  assign dm_ar     = dm_ar_q;
  assign dm_ai     = dm_ai_q;
  assign sym_cnt   = sym_cnt_q;
  assign short_err = short_err_q;

  // ---------------------------------------------------------------------
  // Output FIFO (2 x 128), independent of ce
  // ---------------------------------------------------------------------
  logic [127:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         ovf_err_q, ovf_err_d;
  logic         full, pop, push_ok;

  assign full = (cnt_q == 2'd2);
  assign pop  = (cnt_q != 2'd0) && wr_ready;
  // When full, a same-cycle pop frees the slot being written: wr_ptr == rd_ptr.
  assign push_ok = dm_word_valid && (!full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_err_d = ovf_err_q;
    if (push_ok) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (dm_word_valid && full && !pop) begin
      ovf_err_d = 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
    always_ff @(posedge CLK) begin
      if (RST) begin
        mem_q[gi] <= '0;
      end else if (push_ok && (wr_ptr_q == 1'(gi))) begin
        mem_q[gi] <= dm_word;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  assign wr_valid = (cnt_q != 2'd0);
  assign wr_data  = mem_q[rd_ptr_q];
  assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_iqdemap_sched.sv
// Directed self-checking bench for iqdemap_sched.
module tb_iqdemap_sched;

  logic         CLK = 1'b0;
  logic         RST;
  logic         ce;
  logic         sym_start;
  logic         valid_i;
  logic [10:0]  ar;
  logic [10:0]  ai;
  logic         dm_valid;
  logic [10:0]  dm_ar;
  logic [10:0]  dm_ai;
  logic         dm_word_valid;
  logic [127:0] dm_word;
  logic         wr_valid;
  logic [127:0] wr_data;
  logic         wr_ready;
  logic [15:0]  sym_cnt;
  logic         short_err;
  logic         ovf_err;

  iqdemap_sched dut (
    .CLK(CLK), .RST(RST), .ce(ce), .sym_start(sym_start), .valid_i(valid_i),
    .ar(ar), .ai(ai), .dm_valid(dm_valid), .dm_ar(dm_ar), .dm_ai(dm_ai),
    .dm_word_valid(dm_word_valid), .dm_word(dm_word),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .sym_cnt(sym_cnt), .short_err(short_err), .ovf_err(ovf_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int fwd_q[$];
  int exp_q[$];
  int ai_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Records each carrier the demapper would take: dm_valid at an edge with ce=1.
  always @(negedge CLK) begin
    if (!RST && ce && dm_valid) begin
      fwd_q.push_back(int'($signed(dm_ar)));
      if (dm_ai !== 11'(-int'($signed(dm_ar)))) ai_bad++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; ce = 1'b0; sym_start = 1'b0; valid_i = 1'b0; ar = '0; ai = '0;
    dm_word_valid = 1'b0; dm_word = '0; wr_ready = 1'b0;
    tick(); tick();
    RST = 1'b0;
    fwd_q.delete(); exp_q.delete(); ai_bad = 0;
  endtask

  // Carriers lo..hi with ar=k, ai=-k; sym_start on the first if ss_first.
  // With tog set, each carrier is preceded by a ce=0 cycle carrying junk.
  task automatic send_range(input int lo, input int hi, input bit ss_first, input bit tog);
    for (int k = lo; k <= hi; k++) begin
      if (tog) begin
        ce = 1'b0; valid_i = 1'b1; sym_start = 1'b1; ar = 11'd127; ai = 11'd5;
        tick();
      end
      ce = 1'b1; valid_i = 1'b1; sym_start = ss_first && (k == lo);
      ar = 11'(k); ai = 11'(-k);
      tick();
    end
  endtask

  task automatic idle();
    ce = 1'b1; valid_i = 1'b0; sym_start = 1'b0;
    tick();
  endtask

  // Expected forwarded indices for k in [lo,hi] at pilot phase ph.
  task automatic exp_add(input int lo, input int hi, input int ph);
    for (int k = lo; k <= hi; k++) begin
      if ((k % 12) != ph) exp_q.push_back(k);
    end
  endtask

  task automatic cmp_fwd(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < fwd_q.size(); i++) begin
      if (fwd_q[i] != exp_q[i]) mism++;
    end
    chk({tag, "_count"}, 128'(fwd_q.size()), 128'(exp_q.size()));
    chk({tag, "_order"}, 128'(mism), 128'd0);
    chk({tag, "_ai"}, 128'(ai_bad), 128'd0);
    fwd_q.delete(); exp_q.delete(); ai_bad = 0;
  endtask

  localparam logic [127:0] WA = {4{32'hA0A0_0001}};
  localparam logic [127:0] WB = {4{32'hB0B0_0002}};
  localparam logic [127:0] WC = {4{32'hC0C0_0003}};
  localparam logic [127:0] WD = {4{32'hD0D0_0004}};

  initial begin
    // Reset values
    do_reset();
    chk("rst_dm_valid", 128'(dm_valid), 128'd0);
    chk("rst_dm_ar", 128'(dm_ar), 128'd0);
    chk("rst_dm_ai", 128'(dm_ai), 128'd0);
    chk("rst_wr_valid", 128'(wr_valid), 128'd0);
    chk("rst_wr_data", wr_data, 128'd0);
    chk("rst_sym_cnt", 128'(sym_cnt), 128'd0);
    chk("rst_short", 128'(short_err), 128'd0);
    chk("rst_ovf", 128'(ovf_err), 128'd0);

    // Two back-to-back symbols, phases 0 and 3
    send_range(0, 107, 1'b1, 1'b0);
    send_range(0, 107, 1'b1, 1'b0);
    idle();
    exp_add(0, 107, 0);
    exp_add(0, 107, 3);
    cmp_fwd("b2b");
    chk("b2b_sym_cnt", 128'(sym_cnt), 128'd2);

    // Phases 6, 9, then back to 0
    send_range(0, 107, 1'b1, 1'b0); idle(); exp_add(0, 107, 6); cmp_fwd("ph6");
    send_range(0, 107, 1'b1, 1'b0); idle(); exp_add(0, 107, 9); cmp_fwd("ph9");
    send_range(0, 107, 1'b1, 1'b0); idle(); exp_add(0, 107, 0); cmp_fwd("ph0_wrap");
    chk("wrap_sym_cnt", 128'(sym_cnt), 128'd5);

    // ce toggling: same result as ce held high
    do_reset();
    send_range(0, 107, 1'b1, 1'b1);
    send_range(0, 107, 1'b1, 1'b1);
    idle();
    exp_add(0, 107, 0);
    exp_add(0, 107, 3);
    cmp_fwd("ce_tog");
    chk("ce_tog_sym_cnt", 128'(sym_cnt), 128'd2);

    // Early sym_start at k=50
    do_reset();
    send_range(0, 49, 1'b1, 1'b0);
    chk("early_pre_short", 128'(short_err), 128'd0);
    send_range(0, 0, 1'b1, 1'b0);
    chk("early_short", 128'(short_err), 128'd1);
    chk("early_sym_cnt", 128'(sym_cnt), 128'd0);
    send_range(1, 107, 1'b0, 1'b0);
    idle();
    exp_add(0, 49, 0);
    exp_add(0, 107, 3);
    cmp_fwd("early");
    chk("early_done_cnt", 128'(sym_cnt), 128'd1);
    chk("early_short_sticky", 128'(short_err), 128'd1);

    // FIFO overflow: push A, B, C with wr_ready low
    do_reset();
    dm_word_valid = 1'b1; dm_word = WA; tick();
    chk("fifo_lat_valid", 128'(wr_valid), 128'd1);
    dm_word = WB; tick();
    chk("fifo_ovf_before", 128'(ovf_err), 128'd0);
    dm_word = WC; tick();
    dm_word_valid = 1'b0; dm_word = '0;
    chk("fifo_ovf", 128'(ovf_err), 128'd1);
    tick();
    chk("fifo_head_hold", wr_data, WA);
    wr_ready = 1'b1;
    chk("fifo_drain0", wr_data, WA);
    tick();
    chk("fifo_drain1", wr_data, WB);
    chk("fifo_drain1_v", 128'(wr_valid), 128'd1);
    tick();
    chk("fifo_empty", 128'(wr_valid), 128'd0);
    chk("fifo_ovf_sticky", 128'(ovf_err), 128'd1);

    // Full FIFO, simultaneous push D and pop
    do_reset();
    chk("fifo2_ovf_clr", 128'(ovf_err), 128'd0);
    dm_word_valid = 1'b1; dm_word = WA; tick();
    dm_word = WB; tick();
    dm_word = WD; wr_ready = 1'b1; tick();
    dm_word_valid = 1'b0; dm_word = '0;
    chk("fifo2_ovf", 128'(ovf_err), 128'd0);
    chk("fifo2_head_b", wr_data, WB);
    tick();
    chk("fifo2_head_d", wr_data, WD);
    chk("fifo2_valid_d", 128'(wr_valid), 128'd1);
    tick();
    chk("fifo2_empty", 128'(wr_valid), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
